// File: rtl/maxpool_window_sched_pkg.sv
// Shared definitions for the max-pool window scheduler: FSM encoding,
// default word width and linear address helpers.
package maxpool_window_sched_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Channel-major input map: (c*H + y)*W + x
    function automatic int in_addr(input int c, input int y, input int x,
                                   input int h, input int w);
        return (c * h + y) * w + x;
    endfunction

    function automatic int out_addr(input int c, input int oy, input int ox,
                                    input int oh, input int ow);
        return (c * oh + oy) * ow + ox;
    endfunction

endpackage

// File: rtl/maxpool_running_max.sv
// Signed running-maximum register: the first word of a window loads
// directly, later words replace it only when strictly greater.
module maxpool_running_max
    import maxpool_window_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] max_val
);

    always_ff @(posedge clk) begin
        if (reset) begin
            max_val <= '0;
        end else if (en && (first || ($signed(din) > $signed(max_val)))) begin
            max_val <= din;
        end
    end

endmodule

// File: rtl/maxpool_window_sched.sv
// Max-pool window scheduler: walks a channel-major feature map through one
// shared comparator. Optional stall counter under MAXPOOL_SCHED_PERF_EN.
module maxpool_window_sched
    import maxpool_window_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int D          = 2,
    parameter int H          = 9,
    parameter int W          = 9,
    parameter int K          = 9,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
`ifdef MAXPOOL_SCHED_PERF_EN
    output logic [31:0]           stall_cycles,
`endif
    output state_t                dbg_state
);

    localparam int OH = H / K;
    localparam int OW = W / K;

    state_t      state, state_nx;
    logic [15:0] c, oy, ox, ky, kx;
    logic        rd_vld_q, rd_first_q;
    logic        last_kx, last_ky, win_last, pt_last, wr_fire;

    // Write handshake: a result transfers on any cycle with wr_valid && wr_ready;
    // wr_valid, wr_addr and wr_data hold until that cycle.
    assign last_kx  = (kx == 16'(K - 1));
    assign last_ky  = (ky == 16'(K - 1));
    assign win_last = last_kx && last_ky;
    assign pt_last  = (c == 16'(D - 1)) && (oy == 16'(OH - 1)) && (ox == 16'(OW - 1));
    assign wr_fire  = (state == S_WRITE) && wr_ready;

    assign rd_addr   = ADDR_WIDTH'(in_addr(int'(c), int'(oy) * K + int'(ky),
                                           int'(ox) * K + int'(kx), H, W));
    assign wr_addr   = ADDR_WIDTH'(out_addr(int'(c), int'(oy), int'(ox), OH, OW));
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_READ;
            end
            S_READ: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (win_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy     = 1'b1;
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                wr_valid = 1'b1;
                if (wr_ready) state_nx = pt_last ? S_DONE : S_READ;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Window counters wrap to zero on their own, so IDLE always sees zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            c          <= '0;
            oy         <= '0;
            ox         <= '0;
            ky         <= '0;
            kx         <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
        end else begin
            rd_vld_q   <= rd_en;
            rd_first_q <= rd_en && (kx == 16'd0) && (ky == 16'd0);
            if (state == S_READ) begin
                if (last_kx) begin
                    kx <= '0;
                    ky <= last_ky ? 16'd0 : ky + 16'd1;
                end else begin
                    kx <= kx + 16'd1;
                end
            end
            if (wr_fire) begin
                if (ox == 16'(OW - 1)) begin
                    ox <= '0;
                    if (oy == 16'(OH - 1)) begin
                        oy <= '0;
                        c  <= (c == 16'(D - 1)) ? 16'd0 : c + 16'd1;
                    end else begin
                        oy <= oy + 16'd1;
                    end
                end else begin
                    ox <= ox + 16'd1;
                end
            end
        end
    end

    maxpool_running_max #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_max (
        .clk     (clk),
        .reset   (reset),
        .en      (rd_vld_q),
        .first   (rd_first_q),
        .din     (rd_data),
        .max_val (wr_data)
    );

`ifdef MAXPOOL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)                          stall_cycles <= '0;
        else if (state == S_IDLE && start)  stall_cycles <= '0;
        else if (wr_valid && !wr_ready)     stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_maxpool_window_sched.sv
// Bench for maxpool_window_sched: two configurations, random feature maps,
// reference pooling model, stall/reset/restart boundary cases.
module tb_maxpool_window_sched;
    import maxpool_window_sched_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DA = 2, HA = 9,  WA = 9,  KA = 9;
    localparam int DB = 1, HB = 18, WB = 18, KB = 9;
    localparam int LAT_A = DA * (HA / KA) * (WA / KA) * (KA * KA + 2) + 2;
    localparam int LAT_B = DB * (HB / KB) * (WB / KB) * (KB * KB + 2) + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          start_a = 1'b0, start_b = 1'b0;
    logic          busy_a, done_a, rd_en_a, wr_valid_a;
    logic          busy_b, done_b, rd_en_b, wr_valid_b;
    logic          wr_ready_a = 1'b1, wr_ready_b = 1'b1;
    logic [AW-1:0] rd_addr_a, wr_addr_a, rd_addr_b, wr_addr_b;
    logic [DW-1:0] rd_data_a, wr_data_a, rd_data_b, wr_data_b;
    state_t        dbg_a, dbg_b;
`ifdef MAXPOOL_SCHED_PERF_EN
    logic [31:0]   stall_a, stall_b;
`endif

    maxpool_window_sched #(.DATA_WIDTH(DW), .D(DA), .H(HA), .W(WA), .K(KA), .ADDR_WIDTH(AW)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
`ifdef MAXPOOL_SCHED_PERF_EN
        .stall_cycles(stall_a),
`endif
        .dbg_state(dbg_a)
    );

    maxpool_window_sched #(.DATA_WIDTH(DW), .D(DB), .H(HB), .W(WB), .K(KB), .ADDR_WIDTH(AW)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
`ifdef MAXPOOL_SCHED_PERF_EN
        .stall_cycles(stall_b),
`endif
        .dbg_state(dbg_b)
    );

    // ---------------- buffer memories (1-cycle read latency) ----------------
    logic [DW-1:0] mem_a [DA*HA*WA];
    logic [DW-1:0] mem_b [DB*HB*WB];
    always @(posedge clk) rd_data_a <= rd_en_a ? mem_a[rd_addr_a] : DW'($urandom);
    always @(posedge clk) rd_data_b <= rd_en_b ? mem_b[rd_addr_b] : DW'($urandom);

    // ---------------- monitors ----------------
    logic [AW-1:0] rd_obs_a[$], rd_obs_b[$];
    logic [31:0]   wr_obs_a[$], wr_obs_b[$];
    int done_cnt_a = 0, done_cyc_a = 0, start_cyc_a = 0;
    int done_cnt_b = 0, done_cyc_b = 0, start_cyc_b = 0;
    bit rnd_ready_a = 1'b0;

    always @(negedge clk) begin
        if (rd_en_a) rd_obs_a.push_back(rd_addr_a);
        if (wr_valid_a && wr_ready_a) wr_obs_a.push_back({wr_addr_a, wr_data_a});
        if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
        if (rd_en_b) rd_obs_b.push_back(rd_addr_b);
        if (wr_valid_b && wr_ready_b) wr_obs_b.push_back({wr_addr_b, wr_data_b});
        if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    end

    always @(posedge clk) begin
        if (rnd_ready_a) begin
            #1;
            wr_ready_a = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0, n_err = 0;
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_rd_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pooling reference straight from the definition: max over each KxK tile.
    task automatic build_model(input bit sel_b, input int d, input int h, input int w, input int k);
        exp_q.delete();
        exp_rd_q.delete();
        for (int c = 0; c < d; c++)
            for (int oy = 0; oy < h / k; oy++)
                for (int ox = 0; ox < w / k; ox++) begin
                    int best = 0;
                    for (int ky = 0; ky < k; ky++)
                        for (int kx = 0; kx < k; kx++) begin
                            int a = (c * h + oy * k + ky) * w + ox * k + kx;
                            int v = sel_b ? int'($signed(mem_b[a])) : int'($signed(mem_a[a]));
                            exp_rd_q.push_back(AW'(a));
                            if ((ky == 0 && kx == 0) || v > best) best = v;
                        end
                    exp_q.push_back({16'((c * (h / k) + oy) * (w / k) + ox), 16'(best)});
                end
    endtask

    task automatic compare_layer(input string tag, input bit sel_b);
        logic [31:0]   wq[$];
        logic [AW-1:0] rq[$];
        if (sel_b) begin wq = wr_obs_b; rq = rd_obs_b; end
        else       begin wq = wr_obs_a; rq = rd_obs_a; end
        check({tag, "_nwr"}, 64'(wq.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check({tag, "_wr"}, (i < wq.size()) ? 64'(wq[i]) : 64'bx, 64'(exp_q[i]));
        check({tag, "_nrd"}, 64'(rq.size()), 64'(exp_rd_q.size()));
        for (int i = 0; i < exp_rd_q.size(); i++)
            check({tag, "_rd"}, (i < rq.size()) ? 64'(rq[i]) : 64'bx, 64'(exp_rd_q[i]));
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_ctl"}, {busy_a, done_a, rd_en_a, wr_valid_a}, 4'b0000);
        check({tag, "_rdaddr"}, rd_addr_a, 0);
        check({tag, "_wraddr"}, wr_addr_a, 0);
        check({tag, "_wrdata"}, wr_data_a, 0);
        check({tag, "_state"}, 64'(dbg_a), 64'(S_IDLE));
    endtask

    // ---------------- drivers ----------------
    task automatic pulse_start_a();
        @(posedge clk); #1;
        rd_obs_a.delete();
        wr_obs_a.delete();
        start_a = 1'b1;
        start_cyc_a = cyc;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int bound);
        int c0 = done_cnt_a;
        int n = 0;
        while (done_cnt_a == c0 && n < bound) begin @(posedge clk); n++; end
        check({tag, "_done"}, 64'(done_cnt_a - c0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic fill_a_random(input int mode);
        logic [DW-1:0] pick [4];
        pick[0] = 16'h7FFF; pick[1] = 16'h8000; pick[2] = 16'h0000; pick[3] = 16'hFFFF;
        for (int i = 0; i < DA*HA*WA; i++)
            mem_a[i] = (mode == 1) ? pick[$urandom_range(0, 3)] : DW'($urandom);
    endtask

    task automatic run_a(input string tag, input bit check_lat);
        build_model(1'b0, DA, HA, WA, KA);
        pulse_start_a();
        wait_done_a(tag, 4000);
        if (check_lat) check({tag, "_lat"}, 64'(done_cyc_a - start_cyc_a + 1), 64'(LAT_A));
        compare_layer(tag, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        int n, c0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_a("reset");
        reset = 1'b0;

        // plateau with single peaks per channel
        for (int i = 0; i < DA*HA*WA; i++) mem_a[i] = 16'h4000;
        mem_a[$urandom_range(0, 80)] = 16'h4500;
        repeat (4) mem_a[$urandom_range(81, 161)] = 16'h4200;
        run_a("peaks", 1'b1);
        check("peaks_w0", (wr_obs_a.size() > 0) ? 64'(wr_obs_a[0]) : 64'bx, 64'h0000_4500);
        check("peaks_w1", (wr_obs_a.size() > 1) ? 64'(wr_obs_a[1]) : 64'bx, 64'h0001_4200);
`ifdef MAXPOOL_SCHED_PERF_EN
        check("peaks_stall", stall_a, 0);
`endif

        // all-negative channel 0, maximum is -1
        for (int i = 0; i < DA*HA*WA; i++)
            mem_a[i] = (i < 81) ? DW'($urandom_range(16'h8000, 16'hFFF0)) : DW'($urandom);
        mem_a[$urandom_range(0, 80)] = 16'hFFFF;
        run_a("neg", 1'b1);
        check("neg_w0", (wr_obs_a.size() > 0) ? 64'(wr_obs_a[0]) : 64'bx, 64'h0000_FFFF);

        // random maps, tie-heavy map, random backpressure
        fill_a_random(0); run_a("rand0", 1'b1);
        fill_a_random(1); run_a("ties", 1'b1);
        fill_a_random(0);
        rnd_ready_a = 1'b1;
        run_a("bp", 1'b0);
        rnd_ready_a = 1'b0;
        wr_ready_a = 1'b1;

        // five-cycle stall on the first write
        fill_a_random(0);
        build_model(1'b0, DA, HA, WA, KA);
        wr_ready_a = 1'b0;
        pulse_start_a();
        n = 0;
        @(negedge clk);
        while (!wr_valid_a && n < 300) begin @(negedge clk); n++; end
        check("stall_reach", wr_valid_a, 1);
        a0 = wr_addr_a;
        d0 = wr_data_a;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_hold", {wr_valid_a, rd_en_a, wr_addr_a, wr_data_a}, {1'b1, 1'b0, a0, d0});
        end
        @(posedge clk); #1;
        wr_ready_a = 1'b1;
        wait_done_a("stall", 4000);
        check("stall_lat", 64'(done_cyc_a - start_cyc_a + 1), 64'(LAT_A + 5));
        compare_layer("stall", 1'b0);
`ifdef MAXPOOL_SCHED_PERF_EN
        check("stall_cnt", stall_a, 5);
`endif

        // reset in the middle of READ aborts the layer
        fill_a_random(0);
        c0 = done_cnt_a;
        pulse_start_a();
        while (cyc < start_cyc_a + 40) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort_in_read", 64'(dbg_a), 64'(S_READ));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_a("abort");
        repeat (300) @(negedge clk);
        check("abort_nodone", 64'(done_cnt_a - c0), 0);
        run_a("after_abort", 1'b1);

        // start coinciding with reset is dropped
        @(posedge clk); #1;
        reset = 1'b1;
        start_a = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        check_idle_a("rst_start");
        repeat (5) @(negedge clk);
        check("rst_start_quiet", {busy_a, rd_en_a}, 2'b00);

        // second start while busy is ignored
        fill_a_random(0);
        build_model(1'b0, DA, HA, WA, KA);
        c0 = done_cnt_a;
        pulse_start_a();
        repeat (20) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done_a("restart", 4000);
        check("restart_lat", 64'(done_cyc_a - start_cyc_a + 1), 64'(LAT_A));
        compare_layer("restart", 1'b0);
        repeat (200) @(negedge clk);
        check("restart_onedone", 64'(done_cnt_a - c0), 1);
        check("restart_idle", busy_a, 0);

        // 18x18 map, one distinct corner maximum per quadrant
        for (int i = 0; i < DB*HB*WB; i++) mem_b[i] = DW'($urandom_range(0, 255));
        mem_b[0]   = 16'h0101;
        mem_b[17]  = 16'h0202;
        mem_b[306] = 16'h0303;
        mem_b[323] = 16'h0404;
        build_model(1'b1, DB, HB, WB, KB);
        @(posedge clk); #1;
        start_b = 1'b1;
        start_cyc_b = cyc;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (done_cnt_b == 0 && n < 4000) begin @(posedge clk); n++; end
        check("quad_done", 64'(done_cnt_b), 1);
        repeat (2) @(negedge clk);
        check("quad_lat", 64'(done_cyc_b - start_cyc_b + 1), 64'(LAT_B));
        compare_layer("quad", 1'b1);
        for (int i = 0; i < 4; i++)
            check("quad_val", (wr_obs_b.size() > i) ? 64'(wr_obs_b[i]) : 64'bx,
                  64'({16'(i), 8'(i + 1), 8'(i + 1)}));
        check("quad_rd81", (rd_obs_b.size() > 81) ? 64'(rd_obs_b[81]) : 64'bx, 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maxpool_window_sched.md
Name: maxpool_window_sched

Overview:
- Sequences a single shared max-pool comparator across a channel-major feature map in external buffer memory.
- Per output point, issues K*K window reads, tracks the running signed maximum, then writes one result word.
- Replaces the flat-vector max-pool instance for SPP layers. Only one read port, one comparator and one write port are needed, regardless of H, W and D.
- Started by the layer controller; reports busy and a done pulse.

Parameters:
- DATA_WIDTH, 16: word width, signed two's complement fixed point.
- D, 2: channel count.
- H, 9: input height. Must satisfy H >= K.
- W, 9: input width. Must satisfy W >= K.
- K, 9: pool window size and stride (non-overlapping windows).
- ADDR_WIDTH, 16: read/write address width.
- Derived localparams: OH = H/K and OW = W/K, both floor. Remainder rows/columns are ignored.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a layer when the block is IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write is accepted.
- rd_en  out  1  read request.
- rd_addr  out  ADDR_WIDTH  read address = (c*H + y)*W + x.
- rd_data  in  DATA_WIDTH  read data; valid exactly 1 cycle after rd_en.
- wr_valid  out  1  result valid.
- wr_ready  in  1  sink accepts the result when wr_valid && wr_ready.
- wr_addr  out  ADDR_WIDTH  output address = (c*OH + oy)*OW + ox.
- wr_data  out  DATA_WIDTH  pooled maximum.

Behaviour:
- Reset (synchronous, active-high): FSM goes to IDLE and all counters clear. busy, done, rd_en, wr_valid = 0; rd_addr, wr_addr, wr_data = 0. A reset mid-layer aborts the layer with no done pulse, and an in-flight rd_data is discarded.
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: on start, go to READ. Counters c, oy, ox, ky, kx are 0.
- READ: rd_en = 1 every cycle for K*K consecutive cycles. kx is the inner loop, then ky. rd_addr = (c*H + oy*K + ky)*W + ox*K + kx. After the read with kx = ky = K-1, go to DRAIN.
- Running max:
  - The first returned word of a window loads the max register directly (no zero or minimum initialisation).
  - Each subsequent word replaces it only if strictly greater under signed comparison; ties keep the earlier value.
- DRAIN: one cycle, rd_en = 0, absorbs the last word. Next state is WRITE.
- WRITE: wr_valid = 1 with wr_data and wr_addr held stable until wr_ready.
  - On acceptance, advance ox, then oy, then c (c is the outermost loop).
  - If this was the last point (c = D-1, oy = OH-1, ox = OW-1), go to DONE; otherwise go to READ.
- DONE: done = 1 for one cycle, busy falls in the same cycle, next state is IDLE.
- Latency with wr_ready held high: K*K + 2 cycles per output. Total from start to done = D*OH*OW*(K*K+2) + 2 cycles.
- Boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as reset: reset wins.
  - wr_ready held low stalls indefinitely with no reads issued.
- Comparator width is DATA_WIDTH with no saturation. 0x8000 is the minimum value.

Optional Feature:
- Macro MAXPOOL_SCHED_PERF_EN.
- When defined:
  - Adds output stall_cycles [31:0], counting cycles with wr_valid && !wr_ready.
  - The counter clears on an accepted start and on reset, and holds after done.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE/READ/DRAIN/WRITE/DONE);
  - the DATA_WIDTH default;
  - the address-calculation helper functions (input and output linear address).
- One natural sub-module: maxpool_running_max. It contains the signed compare/load register with a first-element load and an update enable.
- Counters and FSM stay in the top module.

Test Plan:
- D=2, H=W=K=9, wr_ready=1; ch0 all 0x4000 except one 0x4500, ch1 all 0x4000 except several 0x4200.
  - Expect exactly 2 writes: (addr 0, 0x4500) then (addr 1, 0x4200).
  - done occurs 168 cycles after start.
- All-negative window: ch0 values 0x8000..0xFFF0 plus one 0xFFFF → writes 0xFFFF (signed -1), not 0x8000 or 0.
- H=W=18, K=9, D=1, each quadrant's max at a distinct corner (0x0101, 0x0202, 0x0303, 0x0404).
  - Expect writes at addrs 0,1,2,3 with those values, in row-major order.
  - rd_addr sequence of the second window starts at 9.
- wr_ready low for 5 cycles at the first WRITE.
  - wr_valid, wr_addr and wr_data stay stable and rd_en stays 0.
  - With MAXPOOL_SCHED_PERF_EN, stall_cycles = 5 at done.
- Reset asserted in READ at cycle 40 → next cycle all outputs 0, FSM in IDLE, no done pulse. A subsequent start runs the full layer correctly.
- Second start pulse while busy → ignored; the write count and done timing are unchanged, with exactly one done pulse.
